// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// valid/ready requesters. Each operation is accepted in IDLE, the ALU is driven
// for one EXEC cycle, and the registered result is returned in RESP.
// Optional macro ALU_OPCHECK_EN: reject alufn codes outside the legal set
// (ALU sees 000000, response is zeroed and rsp_illegal=1).
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FN_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [FN_W-1:0]  req0_alufn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [FN_W-1:0]  req1_alufn,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_illegal,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FN_W-1:0]  alu_alufn,
  input  logic [WIDTH-1:0] alu_otp,
  input  logic             alu_zero,
  input  logic             alu_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             last_grant;
  logic             grant;
  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic             rsp_take;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [FN_W-1:0]  fn_sel;
  logic [FN_W-1:0]  fn_drive;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: accept -> one EXEC cycle -> hold RESP until the owner takes it
  always_comb begin
    next_state = state;
    rsp_take   = grant ? rsp1_ready : rsp0_ready;
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_take) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output comb: round-robin grant in IDLE, request readies and operand select
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    a_sel  = req0_a;
    b_sel  = req0_b;
    fn_sel = req0_alufn;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt1) begin
      a_sel  = req1_a;
      b_sel  = req1_b;
      fn_sel = req1_alufn;
    end
    req0_ready = gnt0;
    req1_ready = gnt1;
  end

  assign accept = gnt0 | gnt1;

`ifdef ALU_OPCHECK_EN
  logic fn_legal;
  logic illegal_q;

  // Legal opcode decode; illegal codes reach the ALU as 000000
  always_comb begin
    fn_legal = 1'b0;
    case (fn_sel)
      FN_W'(6'b000000), FN_W'(6'b000001), FN_W'(6'b000010), FN_W'(6'b000100),
      FN_W'(6'b000101), FN_W'(6'b000110), FN_W'(6'b001000), FN_W'(6'b001001):
        fn_legal = 1'b1;
      default: fn_legal = 1'b0;
    endcase
    fn_drive = fn_legal ? fn_sel : '0;
  end
`else
  assign fn_drive    = fn_sel;
  assign rsp_illegal = 1'b0;
`endif

  // Datapath: latch operands on accept, capture ALU outputs at end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_alufn    <= '0;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
`ifdef ALU_OPCHECK_EN
      illegal_q    <= 1'b0;
      rsp_illegal  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        alu_a      <= a_sel;
        alu_b      <= b_sel;
        alu_alufn  <= fn_drive;
        last_grant <= gnt1;
        grant      <= gnt1;
`ifdef ALU_OPCHECK_EN
        illegal_q  <= !fn_legal;
`endif
      end
      if (state == EXEC) begin
`ifdef ALU_OPCHECK_EN
        if (illegal_q) begin
          rsp_result   <= '0;
          rsp_zero     <= 1'b0;
          rsp_overflow <= 1'b0;
          rsp_illegal  <= 1'b1;
        end else begin
          rsp_result   <= alu_otp;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_overflow;
          rsp_illegal  <= 1'b0;
        end
`else
        rsp_result   <= alu_otp;
        rsp_zero     <= alu_zero;
        rsp_overflow <= alu_overflow;
`endif
      end
      rsp0_valid <= (next_state == RESP) && !grant;
      rsp1_valid <= (next_state == RESP) && grant;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model. Honours ALU_OPCHECK_EN if defined.
module tb_alu_share_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned FN_W  = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [FN_W-1:0]  req0_alufn, req1_alufn;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_overflow, rsp_illegal;
  logic [WIDTH-1:0] alu_a, alu_b, alu_otp;
  logic [FN_W-1:0]  alu_alufn;
  logic             alu_zero, alu_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .FN_W(FN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_alufn(req0_alufn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_alufn(req1_alufn),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_illegal(rsp_illegal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_alufn(alu_alufn),
    .alu_otp(alu_otp), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  // Behavioural ALU: returns {overflow, zero, result}
  function automatic logic [WIDTH+1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [FN_W-1:0] fn);
    logic [WIDTH-1:0] r;
    logic             v;
    v = 1'b0;
    case (fn)
      6'd0: begin r = a + b; v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]); end
      6'd1: begin r = a - b; v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]); end
      6'd2: r = a & b;
      6'd4: r = a | b;
      6'd5: r = a ^ b;
      6'd6: r = a << b[4:0];
      6'd8: r = WIDTH'(a == b);
      6'd9: r = WIDTH'($signed(a) < $signed(b));
      default: r = ~a;
    endcase
    return {v, (r == '0), r};
  endfunction

  // Expected response {illegal, overflow, zero, result} for a request
  function automatic logic [WIDTH+2:0] exp_rsp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [FN_W-1:0] fn);
`ifdef ALU_OPCHECK_EN
    if (!(fn inside {6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9}))
      return {1'b1, {(WIDTH+2){1'b0}}};
`endif
    return {1'b0, alu_ref(a, b, fn)};
  endfunction

  assign {alu_overflow, alu_zero, alu_otp} = alu_ref(alu_a, alu_b, alu_alufn);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_alufn = '0;
    req1_a = '0; req1_b = '0; req1_alufn = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_overflow, rsp_illegal} !== 7'b0)
      begin n_fail++; $display("FAIL reset_flags got=%b exp=0000000",
        {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_overflow, rsp_illegal}); end
    n_tests++;
    if (rsp_result !== '0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", rsp_result); end
    n_tests++;
    if ({alu_a, alu_b, alu_alufn} !== '0) begin n_fail++;
      $display("FAIL reset_alu got a=%h b=%h fn=%b exp=0", alu_a, alu_b, alu_alufn); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_alufn = 6'b000000;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++;
      $display("FAIL add_accept got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    n_tests++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00 || alu_a !== 32'd5 || alu_b !== 32'd7) begin n_fail++;
      $display("FAIL add_exec got v=%b a=%h b=%h exp v=00 a=5 b=7", {rsp0_valid, rsp1_valid}, alu_a, alu_b); end
    tick();
    n_tests++;
    if ({rsp0_valid, rsp1_valid} !== 2'b10) begin n_fail++;
      $display("FAIL add_rsp_valid got=%b exp=10", {rsp0_valid, rsp1_valid}); end
    n_tests++;
    if ({rsp_overflow, rsp_zero, rsp_result} !== {1'b0, 1'b0, 32'd12}) begin n_fail++;
      $display("FAIL add_result got ovf=%b z=%b r=%h exp ovf=0 z=0 r=0000000c", rsp_overflow, rsp_zero, rsp_result); end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    n_tests++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_fail++;
      $display("FAIL add_release got=%b exp=00", {rsp0_valid, rsp1_valid}); end
  endtask

  task automatic test_contention();
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_alufn = 6'b000001;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_alufn = 6'b000101;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++;
      $display("FAIL cont_first got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    tick();
    n_tests++;
    if ({rsp0_valid, rsp1_valid, req1_ready, rsp_zero, rsp_result} !== {4'b1001, 32'd0}) begin n_fail++;
      $display("FAIL cont_rsp0 got v=%b r1rdy=%b z=%b r=%h exp v=10 r1rdy=0 z=1 r=0",
               {rsp0_valid, rsp1_valid}, req1_ready, rsp_zero, rsp_result); end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++;
      $display("FAIL cont_second got=%b exp=01", {req0_ready, req1_ready}); end
    tick();
    req1_valid = 1'b0;
    tick();
    n_tests++;
    if ({rsp0_valid, rsp1_valid, rsp_zero, rsp_result} !== {3'b010, 32'hFF}) begin n_fail++;
      $display("FAIL cont_rsp1 got v=%b z=%b r=%h exp v=01 z=0 r=000000ff",
               {rsp0_valid, rsp1_valid}, rsp_zero, rsp_result); end
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd6; req0_alufn = 6'b000100;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_alufn = 6'b000000;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++;
      $display("FAIL cont_third got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    n_tests++;
    if ({rsp0_valid, rsp_result} !== {1'b1, 32'd7}) begin n_fail++;
      $display("FAIL cont_rsp_third got v=%b r=%h exp v=1 r=7", rsp0_valid, rsp_result); end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    req1_valid = 1'b1; req1_a = 32'h1234; req1_b = 32'h0F0F; req1_alufn = 6'b000010;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++;
      $display("FAIL bp_accept got=%b exp=01", {req0_ready, req1_ready}); end
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23; req0_alufn = 6'b000000;
    tick();
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ({rsp1_valid, rsp0_valid, req0_ready, rsp_result} !== {3'b100, 32'h0204}) begin n_fail++;
        $display("FAIL bp_hold[%0d] got v1=%b v0=%b r0rdy=%b r=%h exp v1=1 v0=0 r0rdy=0 r=00000204",
                 i, rsp1_valid, rsp0_valid, req0_ready, rsp_result); end
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    n_tests++;
    if ({rsp1_valid, req0_ready} !== 2'b01) begin n_fail++;
      $display("FAIL bp_resume got v1=%b r0rdy=%b exp v1=0 r0rdy=1", rsp1_valid, req0_ready); end
    tick();
    req0_valid = 1'b0;
    tick();
    n_tests++;
    if ({rsp0_valid, rsp_result} !== {1'b1, 32'd123}) begin n_fail++;
      $display("FAIL bp_after got v0=%b r=%h exp v0=1 r=0000007b", rsp0_valid, rsp_result); end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
  endtask

  task automatic test_overflow();
    req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_alufn = 6'b000000;
    #1;
    tick();
    req1_valid = 1'b0;
    tick();
    n_tests++;
    if ({rsp1_valid, rsp_overflow, rsp_zero, rsp_result} !== {3'b110, 32'h8000_0000}) begin n_fail++;
      $display("FAIL ovf got v1=%b ovf=%b z=%b r=%h exp v1=1 ovf=1 z=0 r=80000000",
               rsp1_valid, rsp_overflow, rsp_zero, rsp_result); end
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
  endtask

  task automatic test_reset_exec();
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_alufn = 6'b000000;
    #1;
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_overflow, rsp_illegal,
         rsp_result, alu_a, alu_b, alu_alufn} !== '0) begin n_fail++;
      $display("FAIL rst_exec_outputs got v=%b r=%h a=%h b=%h fn=%b exp all 0",
               {rsp0_valid, rsp1_valid}, rsp_result, alu_a, alu_b, alu_alufn); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_fail++;
        $display("FAIL rst_exec_norsp[%0d] got=%b exp=00", i, {rsp0_valid, rsp1_valid}); end
    end
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_alufn = 6'b000000;
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd5; req1_alufn = 6'b000001;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++;
      $display("FAIL rst_exec_prio got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    n_tests++;
    if ({rsp0_valid, rsp_result} !== {1'b1, 32'd3}) begin n_fail++;
      $display("FAIL rst_exec_after got v0=%b r=%h exp v0=1 r=3", rsp0_valid, rsp_result); end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
  endtask

  task automatic test_illegal_opcode();
    logic [FN_W-1:0] exp_fn;
`ifdef ALU_OPCHECK_EN
    exp_fn = 6'b000000;
`else
    exp_fn = 6'b000011;
`endif
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_alufn = 6'b000011;
    #1;
    tick();
    req0_valid = 1'b0;
    n_tests++;
    if (alu_alufn !== exp_fn) begin n_fail++;
      $display("FAIL illegal_alufn got=%b exp=%b", alu_alufn, exp_fn); end
    tick();
    n_tests++;
    if ({rsp0_valid, rsp_illegal, rsp_overflow, rsp_zero, rsp_result} !==
        {1'b1, exp_rsp(32'd10, 32'd3, 6'b000011)}) begin n_fail++;
      $display("FAIL illegal_rsp got v0=%b ill=%b ovf=%b z=%b r=%h exp v0=1 {ill,ovf,z,r}=%h",
               rsp0_valid, rsp_illegal, rsp_overflow, rsp_zero, rsp_result, exp_rsp(32'd10, 32'd3, 6'b000011)); end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] pa [2];
    logic [WIDTH-1:0] pb [2];
    logic [FN_W-1:0]  pf [2];
    bit               pv [2];
    logic [FN_W-1:0]  codes [11];
    logic [WIDTH+2:0] m_exp;
    bit               m_busy, m_resp;
    int               m_owner, m_last, w;
    codes = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9, 6'd3, 6'd7, 6'd63};
    apply_reset();
    pv = '{0, 0};
    m_busy = 0; m_resp = 0; m_owner = 0; m_last = 1; m_exp = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_tests++;
      if ({rsp0_valid, rsp1_valid} !== {m_busy && m_resp && m_owner == 0, m_busy && m_resp && m_owner == 1})
        begin n_fail++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, {rsp0_valid, rsp1_valid},
          {m_busy && m_resp && m_owner == 0, m_busy && m_resp && m_owner == 1}); end
      if (m_busy && m_resp) begin
        n_tests++;
        if ({rsp_illegal, rsp_overflow, rsp_zero, rsp_result} !== m_exp) begin n_fail++;
          $display("FAIL rand_rsp_data cyc=%0d got=%h exp=%h", cyc,
                   {rsp_illegal, rsp_overflow, rsp_zero, rsp_result}, m_exp); end
      end
      rsp0_ready = ($urandom_range(0, 4) < 3);
      rsp1_ready = ($urandom_range(0, 4) < 3);
      for (int r = 0; r < 2; r++) begin
        if (pv[r] && $urandom_range(0, 15) == 0) pv[r] = 0;
        else if (!pv[r] && cyc < 550 && $urandom_range(0, 2) == 0) begin
          pv[r] = 1;
          pa[r] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
          pb[r] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
          pf[r] = codes[$urandom_range(0, 10)];
        end
      end
      req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_alufn = pf[0];
      req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_alufn = pf[1];
      #1;
      w = -1;
      if (!m_busy && pv[0] && (!pv[1] || m_last == 1)) w = 0;
      else if (!m_busy && pv[1]) w = 1;
      n_tests++;
      if ({req0_ready, req1_ready} !== {w == 0, w == 1}) begin n_fail++;
        $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, {req0_ready, req1_ready}, {w == 0, w == 1}); end
      if (w >= 0) begin
        m_busy = 1; m_resp = 0; m_owner = w; m_last = w;
        m_exp = exp_rsp(pa[w], pb[w], pf[w]);
        pv[w] = 0;
      end else if (m_busy && !m_resp) begin
        m_resp = 1;
      end else if (m_busy && m_resp && (m_owner == 1 ? rsp1_ready : rsp0_ready)) begin
        m_busy = 0;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_overflow();
    test_reset_exec();
    test_illegal_opcode();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters, e.g. the integer pipeline (req0) and a branch/address helper (req1).
- Each requester has a valid/ready request channel and a valid/ready response channel; round-robin arbitration.
- Operands are registered, the shared ALU is driven for one EXEC cycle, and the result, zero and overflow are registered back to the granted requester.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width.
- FN_W, 6, ALU function-code width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_alufn  in  FN_W  requester 0 function code.
- req1_valid, req1_ready, req1_a, req1_b, req1_alufn  same as req0, for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp1_valid  out  1  result for requester 1 available.
- rsp1_ready  in  1  requester 1 takes the result.
- rsp_result  out  WIDTH  registered ALU result (shared by both response channels).
- rsp_zero  out  1  registered ALU zero flag.
- rsp_overflow  out  1  registered ALU overflow flag.
- rsp_illegal  out  1  opcode rejected (see Optional Feature).
- alu_a, alu_b  out  WIDTH  to shared ALU operands.
- alu_alufn  out  FN_W  to shared ALU function code.
- alu_otp  in  WIDTH  from shared ALU result.
- alu_zero, alu_overflow  in  1  from shared ALU flags.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, last_grant=1 (so req0 wins first), all ready/valid outputs 0, rsp_* 0, alu_a/alu_b/alu_alufn 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester other than last_grant.
  - Granted reqN_ready=1 for exactly one cycle; operands and alufn latched into alu_a/alu_b/alu_alufn; last_grant updated; go EXEC.
  - reqN_ready is combinational from the valid inputs and state, and is asserted only in IDLE.
- EXEC:
  - alu_* hold the latched values and the ALU settles.
  - At the end of the cycle, alu_otp/alu_zero/alu_overflow are captured into rsp_*; go RESP.
- RESP:
  - rspG_valid=1 for the granted requester G only. rsp_* are held stable.
  - When rspG_ready=1, rspG_valid drops next cycle and the FSM returns to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Timing: accept at cycle N, EXEC at N+1, rsp valid at N+2. Minimum 3 cycles per operation.
- Backpressure: a requester may hold rsp_ready low indefinitely; the arbiter stalls in RESP and other requesters wait. This is not a deadlock condition.
- Request rules: reqN_valid may drop before ready with no effect. reqN_ready never asserts while another operation is in flight.
- alu_* outputs change only on acceptance; they are held in RESP and IDLE.
- Reset mid-operation: any state returns to IDLE asynchronously; the in-flight result is discarded; no response is issued.
- Widths: results pass through unmodified at WIDTH bits; no sign handling in this block.

Optional Feature:
- Macro ALU_OPCHECK_EN.
- Defined:
  - Legal alufn codes: 000000, 000001, 000010, 000100, 000101, 000110, 001000, 001001.
  - An illegal code is still accepted and sequenced with identical timing, but alu_alufn is driven to 000000.
  - Captured response is forced to rsp_result=0, rsp_zero=0, rsp_overflow=0, rsp_illegal=1.
  - rsp_illegal=0 for legal codes.
- Undefined: no check; rsp_illegal tied 0; every code is passed to the ALU as-is.

Test Plan:
- Single add: req0 a=5, b=7, alufn=000000 accepted at cycle 1 -> rsp0_valid at cycle 3, result=12, zero=0, overflow=0; req1 sees no activity.
- Contention: req0 and req1 both valid from reset (req0 sub 9-9, req1 xor 0xF0^0x0F) -> req0 served first (result 0, zero=1), then req1 (result 0xFF); third simultaneous pair -> req0 again.
- Backpressure: rsp1_ready held 0 for 10 cycles -> rsp1_valid and rsp_result stay stable, req0_ready stays 0, service resumes one cycle after rsp1_ready=1.
- Overflow: req1 a=0x7FFFFFFF, b=1, add -> result 0x80000000, overflow=1.
- Reset in EXEC: assert rst_n=0 during EXEC -> all outputs 0 immediately, no rsp_valid after release, next request served normally with req0 priority.
- ALU_OPCHECK_EN: alufn=000011 -> rsp_illegal=1, result 0, latency 2; without the macro -> rsp_illegal=0 and alu_alufn=000011 is observed at the ALU.
